// File: rtl/color_sense_sequencer.sv
// rtl/color_sense_sequencer.sv - gated per-filter edge counter with dominant-colour classification
// Steps red/green/blue/clear filters, counts synchronised sensor edges per gate window, publishes counts and colour.
module color_sense_sequencer #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int MIN_CLEAR     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_freq,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [1:0]       color,
  output logic             valid,
  output logic             busy
);

  localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_GATE, S_STORE, S_CLASSIFY} state_t;
  typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE, CH_CLEAR} chan_t;

  state_t           state_q, state_d;
  chan_t            chan_q, chan_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] work_q, work_d;
  logic [CNT_W-1:0] red_sh_q, red_sh_d, green_sh_q, green_sh_d;
  logic [CNT_W-1:0] blue_sh_q, blue_sh_d, clear_sh_q, clear_sh_d;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d, green_cnt_q, green_cnt_d;
  logic [CNT_W-1:0] blue_cnt_q, blue_cnt_d, clear_cnt_q, clear_cnt_d;
  logic [1:0]       color_q, color_d;
  logic             valid_q, valid_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             edge_pulse;

  // Ties favour the earlier channel: red over green over blue.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] c);
    logic [1:0] res;
    if ($unsigned(32'(c)) < $unsigned(32'(MIN_CLEAR))) res = 2'd0;
    else if (r >= g && r >= b)                         res = 2'd1;
    else if (g >= b)                                   res = 2'd2;
    else                                               res = 2'd3;
    return res;
  endfunction

  assign edge_pulse = sync2_q & ~sync3_q;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cyc_d       = cyc_q;
    work_d      = work_q;
    red_sh_d    = red_sh_q;
    green_sh_d  = green_sh_q;
    blue_sh_d   = blue_sh_q;
    clear_sh_d  = clear_sh_q;
    red_cnt_d   = red_cnt_q;
    green_cnt_d = green_cnt_q;
    blue_cnt_d  = blue_cnt_q;
    clear_cnt_d = clear_cnt_q;
    color_d     = color_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          chan_d  = CH_RED;
          cyc_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          state_d = S_GATE;
          cyc_d   = '0;
          work_d  = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_GATE: begin
        if (edge_pulse && work_q != CNT_MAX) work_d = work_q + CNT_W'(1);
        if (cyc_q == GATE_LAST) begin
          state_d = S_STORE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STORE: begin
        case (chan_q)
          CH_RED:   red_sh_d   = work_q;
          CH_GREEN: green_sh_d = work_q;
          CH_BLUE:  blue_sh_d  = work_q;
          CH_CLEAR: clear_sh_d = work_q;
          default:  red_sh_d   = red_sh_q;
        endcase
        // Publishing on the way into CLASSIFY makes counts, colour and valid appear together.
        if (chan_q == CH_CLEAR) begin
          state_d     = S_CLASSIFY;
          chan_d      = CH_RED;
          red_cnt_d   = red_sh_q;
          green_cnt_d = green_sh_q;
          blue_cnt_d  = blue_sh_q;
          clear_cnt_d = work_q;
          color_d     = classify(red_sh_q, green_sh_q, blue_sh_q, work_q);
          valid_d     = 1'b1;
        end else begin
          state_d = S_SETTLE;
          chan_d  = chan_t'(chan_q + 2'd1);
        end
      end
      S_CLASSIFY: begin
        cyc_d   = '0;
        state_d = continuous ? S_SETTLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      chan_q      <= CH_RED;
      cyc_q       <= '0;
      work_q      <= '0;
      red_sh_q    <= '0;
      green_sh_q  <= '0;
      blue_sh_q   <= '0;
      clear_sh_q  <= '0;
      red_cnt_q   <= '0;
      green_cnt_q <= '0;
      blue_cnt_q  <= '0;
      clear_cnt_q <= '0;
      color_q     <= 2'd0;
      valid_q     <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cyc_q       <= cyc_d;
      work_q      <= work_d;
      red_sh_q    <= red_sh_d;
      green_sh_q  <= green_sh_d;
      blue_sh_q   <= blue_sh_d;
      clear_sh_q  <= clear_sh_d;
      red_cnt_q   <= red_cnt_d;
      green_cnt_q <= green_cnt_d;
      blue_cnt_q  <= blue_cnt_d;
      clear_cnt_q <= clear_cnt_d;
      color_q     <= color_d;
      valid_q     <= valid_d;
      sync1_q     <= sensor_freq;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
    end
  end

  // Filter code {s2,s3}: red 00, green 11, blue 01, clear 10.
  assign s2        = (chan_q == CH_GREEN) || (chan_q == CH_CLEAR);
  assign s3        = (chan_q == CH_GREEN) || (chan_q == CH_BLUE);
  assign red_cnt   = red_cnt_q;
  assign green_cnt = green_cnt_q;
  assign blue_cnt  = blue_cnt_q;
  assign clear_cnt = clear_cnt_q;
  assign color     = color_q;
  assign valid     = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_color_sense_sequencer.sv
// tb/tb_color_sense_sequencer.sv - table, random and corner-case checks of color_sense_sequencer
module tb_color_sense_sequencer;

  localparam int GATE   = 100;
  localparam int SETTLE = 4;
  localparam int MINC   = 10;
  localparam int CH_LEN = SETTLE + GATE + 1;
  localparam int LAT    = 4 * CH_LEN + 1;

  typedef struct {
    int pr; int pg; int pb; int pc; int tol;
    int er; int eg; int eb; int ec; int ecol;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic sf_a = 1'b0;
  logic sf_b = 1'b0;
  logic s2_a, s3_a, s2_b, s3_b;
  logic [15:0] r_a, g_a, b_a, c_a;
  logic [3:0]  r_b, g_b, b_b, c_b;
  logic [1:0]  col_a, col_b;
  logic val_a, val_b, busy_a, busy_b;

  int per [4] = '{4, 10, 20, 3};
  int divs [8] = '{2, 4, 5, 10, 20, 25, 50, 100};
  int fcode [4] = '{0, 3, 1, 2};
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  color_sense_sequencer #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(16), .MIN_CLEAR(MINC)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .sensor_freq(sf_a),
    .s2(s2_a), .s3(s3_a), .red_cnt(r_a), .green_cnt(g_a), .blue_cnt(b_a), .clear_cnt(c_a),
    .color(col_a), .valid(val_a), .busy(busy_a));

  color_sense_sequencer #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(4), .MIN_CLEAR(MINC)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(1'b0), .sensor_freq(sf_b),
    .s2(s2_b), .s3(s3_b), .red_cnt(r_b), .green_cnt(g_b), .blue_cnt(b_b), .clear_cnt(c_b),
    .color(col_b), .valid(val_b), .busy(busy_b));

  function automatic int chan_of(input logic s2v, input logic s3v);
    case ({s2v, s3v})
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference: a steady square wave of period p dividing GATE yields exactly GATE/p edges.
  function automatic int exp_cnt(input int p, input int w);
    int c;
    int mx;
    c  = GATE / p;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic int exp_col(input int r, input int g, input int b, input int c);
    int cnt [3];
    int best;
    if (c < MINC) return 0;
    cnt  = '{r, g, b};
    best = 0;
    for (int i = 1; i < 3; i++) if (cnt[i] > cnt[best]) best = i;
    return best + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    n_checks++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  task automatic check_results(input vec_t v, input string tag, input bit do_b);
    int e [4];
    int p [4];
    int tb;
    chk($sformatf("%s.valid", tag), val_a, 1);
    chk_tol($sformatf("%s.red", tag), r_a, v.er, v.tol);
    chk_tol($sformatf("%s.green", tag), g_a, v.eg, v.tol);
    chk_tol($sformatf("%s.blue", tag), b_a, v.eb, v.tol);
    chk_tol($sformatf("%s.clear", tag), c_a, v.ec, v.tol);
    chk($sformatf("%s.color", tag), col_a, v.ecol);
    if (do_b) begin
      p = '{v.pr, v.pg, v.pb, v.pc};
      for (int i = 0; i < 4; i++) e[i] = exp_cnt(p[i], 4);
      chk($sformatf("%s.w4.valid", tag), val_b, 1);
      tb = (e[0] == 15) ? 0 : v.tol;
      chk_tol($sformatf("%s.w4.red", tag), r_b, e[0], tb);
      tb = (e[1] == 15) ? 0 : v.tol;
      chk_tol($sformatf("%s.w4.green", tag), g_b, e[1], tb);
      tb = (e[2] == 15) ? 0 : v.tol;
      chk_tol($sformatf("%s.w4.blue", tag), b_b, e[2], tb);
      tb = (e[3] == 15) ? 0 : v.tol;
      chk_tol($sformatf("%s.w4.clear", tag), c_b, e[3], tb);
      chk($sformatf("%s.w4.color", tag), col_b, exp_col(e[0], e[1], e[2], e[3]));
    end
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    int n;
    per = '{v.pr, v.pg, v.pb, v.pc};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s.busy_k1", tag), busy_a, 1);
    chk($sformatf("%s.filt_k1", tag), {s2_a, s3_a}, 0);
    n = 1;
    while (val_a !== 1'b1 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
      if (((n - 1) % CH_LEN) == SETTLE + GATE / 2 && (n - 1) / CH_LEN < 4)
        chk($sformatf("%s.filt%0d", tag, (n - 1) / CH_LEN), {s2_a, s3_a}, fcode[(n - 1) / CH_LEN]);
    end
    chk($sformatf("%s.latency", tag), n, LAT);
    check_results(v, tag, 1'b1);
    @(negedge clk);
    chk($sformatf("%s.valid_after", tag), val_a, 0);
    chk($sformatf("%s.busy_after", tag), busy_a, 0);
    chk($sformatf("%s.filt_after", tag), {s2_a, s3_a}, 0);
    repeat (5) @(negedge clk);
    chk_tol($sformatf("%s.red_hold", tag), r_a, v.er, v.tol);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : gen
    int tick;
    int pa;
    int pb;
    tick = 0;
    forever begin
      @(negedge clk);
      tick++;
      pa = per[chan_of(s2_a, s3_a)];
      pb = per[chan_of(s2_b, s3_b)];
      sf_a = (tick % pa) < (pa / 2);
      sf_b = (tick % pb) < (pb / 2);
    end
  end

  initial begin : main
    vec_t tbl [7];
    vec_t v;
    int n;
    int busy_lo;
    int stray;

    tbl[0] = '{4, 10, 20, 3, 1, 25, 10, 5, 33, 1};
    tbl[1] = '{4, 10, 20, 50, 0, 25, 10, 5, 2, 0};
    tbl[2] = '{5, 5, 20, 4, 0, 20, 20, 5, 25, 1};
    tbl[3] = '{10, 4, 20, 5, 0, 10, 25, 5, 20, 2};
    tbl[4] = '{20, 10, 4, 10, 0, 5, 10, 25, 10, 3};
    tbl[5] = '{10, 10, 10, 20, 0, 10, 10, 10, 5, 0};
    tbl[6] = '{25, 10, 10, 2, 0, 4, 10, 10, 50, 2};

    repeat (3) @(negedge clk);
    chk("reset.red", r_a, 0);
    chk("reset.clear", c_a, 0);
    chk("reset.color", col_a, 0);
    chk("reset.valid", val_a, 0);
    chk("reset.busy", busy_a, 0);
    chk("reset.filt", {s2_a, s3_a}, 0);
    chk("reset.w4.busy", busy_b, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.busy", busy_a, 0);

    for (int i = 0; i < 7; i++) run_pass(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      v.pr  = divs[$urandom_range(0, 7)];
      v.pg  = divs[$urandom_range(0, 7)];
      v.pb  = divs[$urandom_range(0, 7)];
      v.pc  = divs[$urandom_range(0, 7)];
      v.tol = 0;
      v.er  = exp_cnt(v.pr, 16);
      v.eg  = exp_cnt(v.pg, 16);
      v.eb  = exp_cnt(v.pb, 16);
      v.ec  = exp_cnt(v.pc, 16);
      v.ecol = exp_col(v.er, v.eg, v.eb, v.ec);
      run_pass(v, $sformatf("rnd%0d", i));
    end

    // Abort in the middle of the green gate window.
    run_pass(tbl[0], "pre_abort");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 1 + CH_LEN + SETTLE + GATE / 2) begin
      @(negedge clk);
      n++;
    end
    chk("abort.filt_green", {s2_a, s3_a}, 3);
    rst_n = 1'b0;
    #1;
    chk("abort.red", r_a, 0);
    chk("abort.green", g_a, 0);
    chk("abort.blue", b_a, 0);
    chk("abort.clear", c_a, 0);
    chk("abort.color", col_a, 0);
    chk("abort.busy", busy_a, 0);
    chk("abort.filt", {s2_a, s3_a}, 0);
    chk("abort.w4.red", r_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (3 * LAT) begin
      @(negedge clk);
      if (val_a !== 1'b0 || busy_a !== 1'b0 || val_b !== 1'b0 || busy_b !== 1'b0) stray++;
    end
    chk("abort.no_activity", stray, 0);
    chk("abort.red_kept0", r_a, 0);
    run_pass(tbl[1], "post_abort");

    // Continuous mode: three spaced passes, then a final one after dropping continuous.
    v = tbl[3];
    per = '{v.pr, v.pg, v.pb, v.pc};
    continuous = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (val_a !== 1'b1 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("cont.first_latency", n, LAT);
    check_results(v, "cont.p1", 1'b1);
    for (int p = 2; p <= 4; p++) begin
      n = 0;
      busy_lo = 0;
      do begin
        @(negedge clk);
        n++;
        if (p == 4 && n == 1) continuous = 1'b0;
        if (busy_a !== 1'b1) busy_lo++;
      end while (val_a !== 1'b1 && n < 3 * LAT);
      chk($sformatf("cont.p%0d.gap", p), n, LAT);
      chk($sformatf("cont.p%0d.busy_held", p), busy_lo, 0);
      check_results(v, $sformatf("cont.p%0d", p), 1'b0);
    end
    @(negedge clk);
    chk("cont.end.busy", busy_a, 0);
    chk("cont.end.filt", {s2_a, s3_a}, 0);
    chk("cont.end.valid", val_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
